// File: rtl/banked_ram.sv
`default_nettype none
// ============================================================================
// Module   : banked_ram
// Purpose  : Banked Hack data memory with combinational read and a parallel
//            zero-fill sweep that clears every bank at once.
// Revision : 1.0 - initial release
// ============================================================================
module banked_ram #(
  parameter int WIDTH          = 16,
  parameter int ADDR_BITS      = 14,
  parameter int BANK_BITS      = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 load,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy
);

  localparam int WORD_BITS  = ADDR_BITS - BANK_BITS;
  localparam int NUM_BANKS  = 1 << BANK_BITS;
  localparam int BANK_DEPTH = 1 << WORD_BITS;
  localparam logic [WORD_BITS-1:0] PTR_LAST = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [WORD_BITS-1:0] clr_ptr, clr_ptr_next;

  logic [BANK_BITS-1:0] bank_sel;
  logic [WORD_BITS-1:0] word_idx;
  logic                 clearing;
  logic                 write_ok;
  logic [WIDTH-1:0]     rd_data [NUM_BANKS];

  assign bank_sel = address[ADDR_BITS-1 -: BANK_BITS];
  assign word_idx = address[WORD_BITS-1:0];
  assign clearing = (state == CLEAR) && rst_n;
  assign write_ok = (state == IDLE) && rst_n && load;

  // ------------------------------------------------------------------
  // Sweep controller
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      IDLE: begin
        if (clear) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      CLEAR: begin
        // The last word is written on the same edge that returns to IDLE.
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == PTR_LAST) begin
          state_next   = IDLE;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = IDLE;
        clr_ptr_next = '0;
      end
    endcase
  end

  assign busy = (state == CLEAR);

  // ------------------------------------------------------------------
  // Storage banks
  // ------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WIDTH-1:0]     mem [BANK_DEPTH];
    logic                 we;
    logic [WORD_BITS-1:0] waddr;
    logic [WIDTH-1:0]     wdata;

    assign we    = clearing || (write_ok && (bank_sel == BANK_BITS'(b)));
    assign waddr = clearing ? clr_ptr : word_idx;
    assign wdata = clearing ? '0 : in;

    always_ff @(posedge clk) begin
      if (we) begin
        mem[waddr] <= wdata;
      end
    end

    assign rd_data[b] = mem[word_idx];
  end

  assign out = busy ? '0 : rd_data[bank_sel];

endmodule
`default_nettype wire

// File: tb/tb_banked_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_ram
// Purpose  : Scoreboard bench for banked_ram (auto-clear and idle-reset builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_banked_ram;

  localparam int WIDTH = 16;
  localparam int ABITS = 9;
  localparam int SWEEP = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n_v;
  logic [1:0]       load_v;
  logic [1:0]       clear_v;
  logic [ABITS-1:0] addr_v [2];
  logic [WIDTH-1:0] in_v   [2];
  logic [WIDTH-1:0] out_v  [2];
  logic             busy_v [2];

  banked_ram #(.WIDTH(WIDTH), .ADDR_BITS(ABITS), .BANK_BITS(3), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n_v[0]), .in(in_v[0]), .address(addr_v[0]),
    .load(load_v[0]), .clear(clear_v[0]), .out(out_v[0]), .busy(busy_v[0])
  );

  banked_ram #(.WIDTH(WIDTH), .ADDR_BITS(ABITS), .BANK_BITS(3), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_v[1]), .in(in_v[1]), .address(addr_v[1]),
    .load(load_v[1]), .clear(clear_v[1]), .out(out_v[1]), .busy(busy_v[1])
  );

  typedef struct {
    int               dut;
    logic [WIDTH-1:0] exp_out;
    bit               chk_out;
    bit               exp_busy;
    string            name;
  } exp_t;

  exp_t queue_exp [$];
  bit   chk_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: consumes one expectation per flagged cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_valid) begin
      if (queue_exp.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: no expectation queued");
      end else begin
        exp_t e;
        e = queue_exp.pop_front();
        checks++;
        if (busy_v[e.dut] !== e.exp_busy) begin
          errors++;
          $display("FAIL %s busy: got %b expected %b", e.name, busy_v[e.dut], e.exp_busy);
        end
        if (e.chk_out) begin
          checks++;
          if (out_v[e.dut] !== e.exp_out) begin
            errors++;
            $display("FAIL %s out: got %h expected %h", e.name, out_v[e.dut], e.exp_out);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int d, input logic [ABITS-1:0] a, input logic [WIDTH-1:0] exp,
                        input bit chk_out, input bit exp_busy, input string name);
    exp_t e;
    addr_v[d] = a;
    e.dut = d; e.exp_out = exp; e.chk_out = chk_out; e.exp_busy = exp_busy; e.name = name;
    queue_exp.push_back(e);
    chk_valid = 1'b1;
    step();
    chk_valid = 1'b0;
  endtask

  task automatic read(input int d, input logic [ABITS-1:0] a, input logic [WIDTH-1:0] exp,
                      input string name);
    sample(d, a, exp, 1'b1, 1'b0, name);
  endtask

  task automatic write(input int d, input logic [ABITS-1:0] a, input logic [WIDTH-1:0] data);
    addr_v[d] = a; in_v[d] = data; load_v[d] = 1'b1;
    step();
    load_v[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    rst_n_v[d] = 1'b0;
    step();
    step();
    rst_n_v[d] = 1'b1;
  endtask

  task automatic pulse_clear(input int d);
    clear_v[d] = 1'b1;
    step();
    clear_v[d] = 1'b0;
  endtask

  // n busy cycles with out forced to 0, optional event (1=load, 2=clear) at
  // cycle ev_at, then optionally one idle cycle reading 0 at the same address.
  task automatic window(input int d, input int n, input bit final_chk, input int ev_at,
                        input int ev_kind, input logic [ABITS-1:0] a,
                        input logic [WIDTH-1:0] data, input string name);
    for (int i = 0; i < n; i++) begin
      if (i == ev_at && ev_kind == 1) begin
        load_v[d] = 1'b1; in_v[d] = data;
      end
      if (i == ev_at && ev_kind == 2) clear_v[d] = 1'b1;
      sample(d, a, '0, 1'b1, 1'b1, name);
      load_v[d] = 1'b0;
      clear_v[d] = 1'b0;
    end
    if (final_chk) sample(d, a, '0, 1'b1, 1'b0, {name, "_end"});
  endtask

  initial begin
    rst_n_v = 2'b00; load_v = 2'b00; clear_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr_v[i] = '0;
      in_v[i]   = '0;
    end

    // ---------------- auto-clear build ----------------
    do_reset(0);
    window(0, SWEEP, 1'b1, -1, 0, 9'h000, '0, "rst_sweep");
    read(0, 9'h000, 16'h0000, "rd0_after_rst");
    read(0, 9'h03F, 16'h0000, "rd63_after_rst");
    read(0, 9'h040, 16'h0000, "rd64_after_rst");
    read(0, 9'h1FF, 16'h0000, "rd511_after_rst");

    write(0, 9'h000, 16'hBEEF);
    write(0, 9'h040, 16'h1234);
    write(0, 9'h1FF, 16'hFFFF);
    read(0, 9'h000, 16'hBEEF, "rd_beef");
    read(0, 9'h040, 16'h1234, "rd_1234");
    read(0, 9'h1FF, 16'hFFFF, "rd_ffff");
    read(0, 9'h001, 16'h0000, "rd_nb001");
    read(0, 9'h1FE, 16'h0000, "rd_nb1fe");

    pulse_clear(0);
    window(0, SWEEP, 1'b1, 2, 1, 9'h005, 16'hAAAA, "clr_sweep");
    read(0, 9'h000, 16'h0000, "rd0_after_clr");
    read(0, 9'h040, 16'h0000, "rd40_after_clr");
    read(0, 9'h1FF, 16'h0000, "rd1ff_after_clr");
    read(0, 9'h005, 16'h0000, "rd5_dropped_write");

    write(0, 9'h1FF, 16'h1111);
    write(0, 9'h100, 16'h2222);
    read(0, 9'h1FF, 16'h1111, "rd_1111");
    pulse_clear(0);
    window(0, 30, 1'b0, -1, 0, 9'h1FF, '0, "part_sweep");
    do_reset(0);
    window(0, SWEEP, 1'b1, -1, 0, 9'h1FF, '0, "restart_sweep");
    read(0, 9'h100, 16'h0000, "rd100_after_restart");

    clear_v[0] = 1'b1;
    write(0, 9'h003, 16'h7777);
    clear_v[0] = 1'b0;
    window(0, SWEEP, 1'b1, -1, 0, 9'h003, '0, "clr_load_sweep");
    read(0, 9'h003, 16'h0000, "rd3_after_clr_load");

    // ---------------- idle-reset build ----------------
    do_reset(1);
    sample(1, 9'h00A, '0, 1'b0, 1'b0, "b_idle_after_rst");
    write(1, 9'h00A, 16'h5555);
    read(1, 9'h00A, 16'h5555, "b_rd_5555");
    write(1, 9'h1C0, 16'h9999);
    read(1, 9'h1C0, 16'h9999, "b_rd_9999");
    pulse_clear(1);
    window(1, SWEEP, 1'b1, 4, 2, 9'h00A, '0, "b_double_clear");
    sample(1, 9'h1C0, '0, 1'b1, 1'b0, "b_still_idle");

    step();
    if (queue_exp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d pending, expected 0", queue_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
